// File: rtl/taxi_trip_counter.sv
// -----------------------------------------------------------------------------
// taxi_trip_counter
//
// Front end of the taximeter. Converts synchronised wheel-revolution pulses and
// a 1 Hz seconds strobe into the distance count (mil) and the waiting-time
// count (timee) consumed by the combinational fare calculator. A three-state
// trip FSM (IDLE / RUN / HOLD) gates all counting.
//
// Optional build macro:
//   TAXI_TRIP_ROUND_UP_EN - when defined, a partial distance unit left in the
//                           pulse counter at flag-up is billed as a whole unit.
//                           When undefined the partial distance is discarded.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   start      in   1  one-cycle flag-down strobe
//   stop       in   1  one-cycle flag-up strobe
//   wheel      in   1  wheel sensor level, already synchronised to clk
//   sec_tick   in   1  one-cycle strobe, once per second
//   mil        out  8  distance units this trip, saturating at 255
//   timee      out  7  waiting-time units this trip, saturating at 127
//   running    out  1  high while in RUN
//   trip_done  out  1  one-cycle pulse after the RUN->HOLD transition
// -----------------------------------------------------------------------------
module taxi_trip_counter #(
    parameter int unsigned PULSES_PER_MILE = 10,  // 1..1023
    parameter int unsigned STILL_SECS      = 3,   // 1..15
    parameter int unsigned WAIT_SECS       = 60   // 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       wheel,
    input  logic       sec_tick,
    output logic [7:0] mil,
    output logic [6:0] timee,
    output logic       running,
    output logic       trip_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [9:0] PULSE_LAST = 10'(PULSES_PER_MILE - 1);
    localparam logic [3:0] STILL_MAX  = 4'(STILL_SECS);
    localparam logic [7:0] WAIT_LAST  = 8'(WAIT_SECS - 1);
    localparam logic [7:0] MIL_MAX    = 8'hFF;
    localparam logic [6:0] TIMEE_MAX  = 7'h7F;

    state_t     state_q,     state_d;
    logic [7:0] mil_q,       mil_d;
    logic [6:0] timee_q,     timee_d;
    logic [9:0] pulse_cnt_q, pulse_cnt_d;
    logic [3:0] still_cnt_q, still_cnt_d;
    logic [7:0] wait_cnt_q,  wait_cnt_d;
    logic       running_q,   running_d;
    logic       trip_done_q, trip_done_d;
    logic       wheel_q;     // wheel level from the previous cycle

    logic wheel_edge;
    logic stationary;
    logic go_run;
    logic go_hold;

    assign wheel_edge = wheel & ~wheel_q;
    assign stationary = (still_cnt_q == STILL_MAX);

    // start has priority outside RUN, stop has priority inside RUN, so the two
    // transitions can never both fire in the same cycle.
    assign go_run  = start && (state_q != RUN);
    assign go_hold = stop  && (state_q == RUN);

    always_comb begin
        // NOTE: every variable driven here gets a default first so that no path
        // leaves it unassigned; a missing default would infer a latch.
        state_d     = state_q;
        mil_d       = mil_q;
        timee_d     = timee_q;
        pulse_cnt_d = pulse_cnt_q;
        still_cnt_d = still_cnt_q;
        wait_cnt_d  = wait_cnt_q;

        if (go_run) begin
            state_d = RUN;
        end else if (go_hold) begin
            state_d = HOLD;
        end

        // Counting happens in every RUN cycle, including the one in which stop
        // arrives, so an edge or tick coinciding with flag-up is still billed.
        if (state_q == RUN) begin
            if (wheel_edge) begin
                // An edge always wins over a coincident tick: the car is moving.
                still_cnt_d = '0;
                if (pulse_cnt_q == PULSE_LAST) begin
                    pulse_cnt_d = '0;
                    if (mil_q != MIL_MAX) begin
                        mil_d = mil_q + 8'd1;
                    end
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 10'd1;
                end
            end else if (sec_tick) begin
                if (stationary) begin
                    // wait_cnt is never cleared by motion, so partial waiting
                    // seconds carry over between stationary periods.
                    if (wait_cnt_q == WAIT_LAST) begin
                        wait_cnt_d = '0;
                        if (timee_q != TIMEE_MAX) begin
                            timee_d = timee_q + 7'd1;
                        end
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    // The tick that reaches STILL_SECS only marks the car as
                    // stationary; waiting starts with the following tick.
                    still_cnt_d = still_cnt_q + 4'd1;
                end
            end
        end

`ifdef TAXI_TRIP_ROUND_UP_EN
        // Bill a partly travelled unit as a whole one at flag-up, looking at
        // the pulse count after this cycle's edge has been applied.
        if (go_hold && (pulse_cnt_d != '0) && (mil_d != MIL_MAX)) begin
            mil_d = mil_d + 8'd1;
        end
`endif

        // A new trip starts from zero with the car considered stationary.
        if (go_run) begin
            mil_d       = '0;
            timee_d     = '0;
            pulse_cnt_d = '0;
            wait_cnt_d  = '0;
            still_cnt_d = STILL_MAX;
        end
    end

    assign running_d   = (state_d == RUN);
    assign trip_done_d = go_hold;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so that every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= IDLE;
            mil_q       <= '0;
            timee_q     <= '0;
            pulse_cnt_q <= '0;
            still_cnt_q <= '0;
            wait_cnt_q  <= '0;
            running_q   <= 1'b0;
            trip_done_q <= 1'b0;
            wheel_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mil_q       <= mil_d;
            timee_q     <= timee_d;
            pulse_cnt_q <= pulse_cnt_d;
            still_cnt_q <= still_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            running_q   <= running_d;
            trip_done_q <= trip_done_d;
            wheel_q     <= wheel;
        end
    end

    assign mil       = mil_q;
    assign timee     = timee_q;
    assign running   = running_q;
    assign trip_done = trip_done_q;

endmodule

// File: tb/tb_taxi_trip_counter.sv
// -----------------------------------------------------------------------------
// tb_taxi_trip_counter
//
// Self-checking bench for taxi_trip_counter with PULSES_PER_MILE=10,
// STILL_SECS=3, WAIT_SECS=60. A table of per-cycle vectors covers reset,
// FSM transitions and start/stop priority; hand-written sequences cover the
// multi-cycle distance, waiting-time and saturation behaviour.
// -----------------------------------------------------------------------------
module tb_taxi_trip_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       wheel;
    logic       sec_tick;
    logic [7:0] mil;
    logic [6:0] timee;
    logic       running;
    logic       trip_done;

`ifdef TAXI_TRIP_ROUND_UP_EN
    localparam int RU = 1;
`else
    localparam int RU = 0;
`endif

    taxi_trip_counter #(
        .PULSES_PER_MILE(10),
        .STILL_SECS     (3),
        .WAIT_SECS      (60)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .wheel    (wheel),
        .sec_tick (sec_tick),
        .mil      (mil),
        .timee    (timee),
        .running  (running),
        .trip_done(trip_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic       wheel;
        logic       tick;
        logic [7:0] mil;
        logic [6:0] timee;
        logic       running;
        logic       done;
    } vec_t;

    typedef struct {
        logic [7:0] mil;
        logic [6:0] timee;
        logic       running;
        logic       done;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[14];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock once, and leave the bench 1 ns after the
    // rising edge where registered outputs are stable.
    task automatic apply(input logic r, input logic s, input logic p,
                         input logic w, input logic t);
        rst      = r;
        start    = s;
        stop     = p;
        wheel    = w;
        sec_tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic p,
                                input logic w, input logic t, input int m,
                                input int tm, input logic run, input logic done);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.wheel = w; v.tick = t;
        v.mil = 8'(m); v.timee = 7'(tm); v.running = run; v.done = done;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t got;

        rst = 1'b1; start = 1'b0; stop = 1'b0; wheel = 1'b0; sec_tick = 1'b0;
        @(negedge clk);

        //           rst start stop wheel tick  mil  timee run done
        vecs[0]  = mk(1, 0, 0, 0, 0,  0,  0, 0, 0);  // reset state
        vecs[1]  = mk(0, 0, 0, 1, 0,  0,  0, 0, 0);  // edge in IDLE ignored
        vecs[2]  = mk(0, 0, 0, 0, 1,  0,  0, 0, 0);  // tick in IDLE ignored
        vecs[3]  = mk(0, 0, 1, 0, 0,  0,  0, 0, 0);  // stop in IDLE ignored
        vecs[4]  = mk(0, 1, 0, 0, 0,  0,  0, 1, 0);  // IDLE -> RUN
        vecs[5]  = mk(0, 0, 0, 1, 0,  0,  0, 1, 0);  // one pulse, no unit yet
        vecs[6]  = mk(0, 0, 1, 0, 0, RU,  0, 0, 1);  // RUN -> HOLD, partial unit
        vecs[7]  = mk(0, 0, 0, 0, 0, RU,  0, 0, 0);  // trip_done is one cycle
        vecs[8]  = mk(0, 0, 0, 1, 0, RU,  0, 0, 0);  // edge in HOLD frozen
        vecs[9]  = mk(0, 1, 1, 0, 0,  0,  0, 1, 0);  // start+stop in HOLD: RUN
        vecs[10] = mk(0, 1, 1, 0, 0,  0,  0, 0, 1);  // start+stop in RUN: HOLD
        vecs[11] = mk(0, 1, 0, 0, 0,  0,  0, 1, 0);  // HOLD -> RUN
        vecs[12] = mk(0, 1, 0, 0, 0,  0,  0, 1, 0);  // start in RUN: stays RUN
        vecs[13] = mk(1, 1, 0, 0, 0,  0,  0, 0, 0);  // rst beats start

        for (int i = 0; i < 14; i++) begin
            exp_t e;
            e.mil = vecs[i].mil; e.timee = vecs[i].timee;
            e.running = vecs[i].running; e.done = vecs[i].done;
            sb_q.push_back(e);
            apply(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].wheel, vecs[i].tick);
            got = sb_q.pop_front();
            check($sformatf("vec%0d.mil", i),       mil,       got.mil);
            check($sformatf("vec%0d.timee", i),     timee,     got.timee);
            check($sformatf("vec%0d.running", i),   running,   got.running);
            check($sformatf("vec%0d.trip_done", i), trip_done, got.done);
        end

        // Reset in the middle of a trip, then a normal restart.
        apply(0, 1, 0, 0, 0);
        edges(9);
        check("dist_9_edges", mil, 0);
        edges(1);
        check("dist_10_edges", mil, 1);
        edges(15);
        check("dist_25_edges", mil, 2);
        check("running_mid_trip", running, 1);
        apply(1, 0, 0, 0, 0);
        check("midrst_mil", mil, 0);
        check("midrst_timee", timee, 0);
        check("midrst_running", running, 0);
        apply(0, 0, 1, 0, 0);
        check("midrst_idle_stop_done", trip_done, 0);
        edges(3);
        check("midrst_idle_edges", mil, 0);
        apply(0, 1, 0, 0, 0);
        check("restart_running", running, 1);
        edges(10);
        check("restart_mil", mil, 1);

        // 25 edges then flag-up: truncated (or rounded-up) distance, done pulse.
        apply(0, 0, 1, 0, 0);
        apply(0, 1, 0, 0, 0);
        check("hold_start_clears_mil", mil, 0);
        edges(25);
        apply(0, 0, 1, 0, 0);
        check("trip25_mil", mil, 2 + RU);
        check("trip25_done", trip_done, 1);
        check("trip25_running", running, 0);
        apply(0, 0, 0, 0, 0);
        check("trip25_done_drop", trip_done, 0);
        edges(12);
        ticks(200);
        check("hold_mil_frozen", mil, 2 + RU);
        check("hold_timee_frozen", timee, 0);

        // stop in the same cycle as the unit-completing edge: edge still counts.
        apply(0, 1, 0, 0, 0);
        check("newtrip_mil", mil, 0);
        edges(19);
        apply(0, 0, 1, 1, 0);
        check("stop_with_edge_mil", mil, 2);
        check("stop_with_edge_done", trip_done, 1);
        apply(0, 0, 0, 0, 0);

        // Long stationary period from flag-down.
        apply(0, 1, 0, 0, 0);
        ticks(183);
        check("wait183_timee", timee, 3);
        check("wait183_mil", mil, 0);
        apply(0, 0, 1, 0, 0);

        // Edge and tick in the same cycle while stationary.
        apply(0, 1, 0, 0, 0);
        edges(1);
        ticks(3);
        ticks(59);
        check("pre_collide_timee", timee, 0);
        apply(0, 0, 0, 1, 1);
        check("collide_timee", timee, 0);
        ticks(3);
        check("restationary_timee", timee, 0);
        ticks(1);
        check("kept_wait_timee", timee, 1);
        apply(0, 0, 1, 0, 0);

        // Saturation of both counters.
        apply(0, 1, 0, 0, 0);
        edges(2549);
        check("sat_mil_254", mil, 254);
        edges(1);
        check("sat_mil_255", mil, 255);
        edges(50);
        check("sat_mil_hold", mil, 255);
        ticks(7563);
        check("sat_timee_126", timee, 126);
        ticks(60);
        check("sat_timee_127", timee, 127);
        ticks(177);
        check("sat_timee_hold", timee, 127);
        check("sat_running", running, 1);
        apply(0, 0, 1, 0, 0);
        check("sat_final_mil", mil, 255);
        check("sat_final_done", trip_done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
